// File: rtl/vram_arbiter.sv
// Purpose : shares the single-port synchronous-read VRAM between the Z80 bus and the VGA fetch engine.
// Latency : VGA fetch data 3 edges after the strobe (fixed); CPU write 1 edge, CPU read 3 edges after grant.
// Backpressure: VGA is never stalled; the CPU is held via combinational cpu_wait_n until its access is served.
module vram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait_n,
  output logic              cpu_starve,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // What each RAM access in flight was for; stage 2 lines up with ram_rdata.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  logic              ram_en_q,    ram_en_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  tag_e              tag1_q,      tag1_d;
  tag_e              tag2_q,      tag2_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              busy_q,      busy_d;
  logic              served_q,    served_d;
  logic              abort_q,     abort_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              starve_q,    starve_d;

  logic grant_vga;
  logic grant_cpu;
  logic cap_cpu;
  logic served_set;

  // Slot grant: VGA strictly first, CPU only with a fresh, not-yet-served, non-overlapping request.
  always_comb begin
    grant_vga  = vga_req;
    grant_cpu  = !vga_req && cpu_req && !served_q && !busy_q;
    cap_cpu    = (tag2_q == TAG_CPU);
    // A read that was abandoned mid-flight must not mark the next bus cycle as served.
    served_set = cpu_req && ((grant_cpu && cpu_we) || (cap_cpu && !abort_q));
  end

  // RAM command register: one-cycle enable per grant, address/data held when idle.
  always_comb begin
    ram_en_d    = grant_vga || grant_cpu;
    ram_we_d    = grant_cpu && cpu_we;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_vga) begin
      ram_addr_d = vga_addr;
    end else if (grant_cpu) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
    end
  end

  // Tag pipeline and read-data capture.
  always_comb begin
    tag1_d = TAG_NONE;
    if (grant_vga) begin
      tag1_d = TAG_VGA;
    end else if (grant_cpu && !cpu_we) begin
      tag1_d = TAG_CPU;
    end
    tag2_d      = tag1_q;
    vga_valid_d = (tag2_q == TAG_VGA);
    vga_rdata_d = (tag2_q == TAG_VGA) ? ram_rdata : vga_rdata_q;
    cpu_rdata_d = cap_cpu ? ram_rdata : cpu_rdata_q;
  end

  // CPU bookkeeping: busy while a read is in flight, served until the bus cycle ends.
  always_comb begin
    busy_d = busy_q;
    if (grant_cpu && !cpu_we) begin
      busy_d = 1'b1;
    end else if (cap_cpu) begin
      busy_d = 1'b0;
    end

    abort_d = abort_q;
    if (cap_cpu) begin
      abort_d = 1'b0;
    end else if (busy_q && !cpu_req) begin
      abort_d = 1'b1;
    end

    served_d = served_q;
    if (!cpu_req) begin
      served_d = 1'b0;
    end else if (served_set) begin
      served_d = 1'b1;
    end
  end

  // Starvation monitor: saturating count of pending cycles, sticky flag once the limit is hit.
  always_comb begin
    if (!cpu_req || served_q || served_set) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT_C) begin
      cnt_d = cnt_q + ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
    starve_d = starve_q || (cnt_d >= LIMIT_C);
  end

  // State registers; reset discards every access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      vga_valid_q <= 1'b0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
      busy_q      <= 1'b0;
      served_q    <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      vga_valid_q <= vga_valid_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      busy_q      <= busy_d;
      served_q    <= served_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  // WAIT must respond within the same T-state, so it stays combinational on cpu_req.
  assign cpu_wait_n = !(cpu_req && !served_q);
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign vga_valid  = vga_valid_q;
  assign vga_rdata  = vga_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_starve = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n;
  logic        cpu_starve;
  logic        vga_req;
  logic [11:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        vga_valid;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int tests = 0;
  int fails = 0;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n), .cpu_starve(cpu_starve),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_valid(vga_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural VRAM: unwritten locations read as addr[7:0]^A5.
  bit [7:0] mem [0:4095];
  bit       written [0:4095];
  always @(posedge clock) begin
    if (ram_en && ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr[7:0] ^ 8'hA5);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int we_pulses;
  int en_cpu_bad;
  int valid_cnt;

  initial begin
    reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    #2;
    // reset state, cpu_req held high
    check("rst_wait_n", cpu_wait_n, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_vga_rdata", vga_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_starve", cpu_starve, 0);
    cpu_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // CPU write 5Ah -> 123h
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
    #1 check("wr_wait_before", cpu_wait_n, 0);
    tick();
    check("wr_en", ram_en, 1);
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, 12'h123);
    check("wr_wdata", ram_wdata, 8'h5A);
    check("wr_wait_after", cpu_wait_n, 1);
    cpu_req = 1'b0;
    tick();
    check("wr_en_drop", ram_en, 0);

    // CPU read 123h
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    tick();
    check("rd_en", ram_en, 1);
    check("rd_we", ram_we, 0);
    check("rd_addr", ram_addr, 12'h123);
    check("rd_wait_c1", cpu_wait_n, 0);
    tick();
    check("rd_wait_c2", cpu_wait_n, 0);
    check("rd_en_c2", ram_en, 0);
    tick();
    check("rd_data", cpu_rdata, 8'h5A);
    check("rd_wait_done", cpu_wait_n, 1);
    cpu_req = 1'b0;
    tick();

    // Collision: VGA 010h vs CPU read 020h
    vga_req = 1'b1; vga_addr = 12'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    tick();
    check("col_vga_addr", ram_addr, 12'h010);
    check("col_vga_we", ram_we, 0);
    vga_req = 1'b0;
    tick();
    check("col_cpu_en", ram_en, 1);
    check("col_cpu_addr", ram_addr, 12'h020);
    tick();
    check("col_vga_valid", vga_valid, 1);
    check("col_vga_rdata", vga_rdata, 8'hB5);
    check("col_cpu_wait", cpu_wait_n, 0);
    tick();
    check("col_vga_valid_drop", vga_valid, 0);
    check("col_cpu_rdata", cpu_rdata, 8'h85);
    check("col_cpu_wait_done", cpu_wait_n, 1);
    cpu_req = 1'b0;
    tick();

    // One access per bus cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h055; cpu_wdata = 8'h3C;
    we_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_we) we_pulses++;
    end
    check("one_access_pulses", we_pulses, 1);
    cpu_req = 1'b0;
    tick();

    // Abort: read 020h, drop, re-raise for read 010h
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    tick();
    check("ab_grant1", ram_addr, 12'h020);
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 12'h010;
    #1 check("ab_wait_reraise", cpu_wait_n, 0);
    tick();
    check("ab_cap1", cpu_rdata, 8'h85);
    check("ab_wait_after_cap1", cpu_wait_n, 0);
    check("ab_no_grant_busy", ram_en, 0);
    tick();
    check("ab_grant2_en", ram_en, 1);
    check("ab_grant2_addr", ram_addr, 12'h010);
    tick();
    check("ab_wait_c2", cpu_wait_n, 0);
    tick();
    check("ab_cap2", cpu_rdata, 8'hB5);
    check("ab_wait_done", cpu_wait_n, 1);
    cpu_req = 1'b0;
    tick();

    // Starvation: 70 back-to-back VGA strobes with a CPU write pending
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0AA; cpu_wdata = 8'h77;
    en_cpu_bad = 0; valid_cnt = 0;
    for (int k = 1; k <= 70; k++) begin
      vga_req = 1'b1; vga_addr = 12'(k);
      tick();
      if (ram_we || !ram_en || ram_addr != 12'(k)) en_cpu_bad++;
      if (vga_valid) valid_cnt++;
      if (k == 63) check("starve_at_63", cpu_starve, 0);
      if (k == 64) check("starve_at_64", cpu_starve, 1);
    end
    check("starve_vga_only", en_cpu_bad, 0);
    check("starve_wait_held", cpu_wait_n, 0);
    vga_req = 1'b0;
    tick();
    if (vga_valid) valid_cnt++;
    check("starve_cpu_we", ram_we, 1);
    check("starve_cpu_addr", ram_addr, 12'h0AA);
    check("starve_cpu_wdata", ram_wdata, 8'h77);
    check("starve_wait_rel", cpu_wait_n, 1);
    cpu_req = 1'b0;
    tick();
    if (vga_valid) valid_cnt++;
    tick();
    if (vga_valid) valid_cnt++;
    check("starve_valid_count", valid_cnt, 70);
    check("starve_sticky", cpu_starve, 1);

    // Reset mid-operation: VGA fetch and CPU read in flight
    vga_req = 1'b1; vga_addr = 12'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    tick();
    vga_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", ram_en, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_starve", cpu_starve, 0);
    check("mid_rst_cpu_rdata", cpu_rdata, 0);
    check("mid_rst_wait_n", cpu_wait_n, 0);
    cpu_req = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    check("mid_rst_no_valid1", vga_valid, 0);
    tick();
    check("mid_rst_no_valid2", vga_valid, 0);
    check("mid_rst_vga_rdata", vga_rdata, 0);
    check("mid_rst_cpu_rdata2", cpu_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
